// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
// ExcCodes, handler entry, MD FSM encoding, T_use "unused" marker, hazard helper.
package pipe_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // One source operand against the E and M producers.
    function automatic logic src_hazard(
        input logic [4:0] s,
        input logic [1:0] tuse,
        input logic [4:0] e_tgt,
        input logic [2:0] e_tnew,
        input logic [4:0] m_tgt,
        input logic [2:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (s == e_tgt) && ({1'b0, tuse} < e_tnew);
        m_hit = (s == m_tgt) && ({1'b0, tuse} < m_tnew);
        return (s != 5'd0) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage-status inputs and control outputs of pipe_ctrl.
// master = pipeline/CP0 side, slave = pipe_ctrl.
interface pipe_ctrl_if;

    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_is_md;
    logic [4:0]  e_target;
    logic [2:0]  e_tnew;
    logic [4:0]  m_target;
    logic [2:0]  m_tnew;
    logic        md_start;
    logic        md_is_div;
    logic [31:0] m_pc;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic [5:0]  hw_int;
    logic [5:0]  int_mask;
    logic        ie;
    logic        exl;

    logic        stall;
    logic        req;
    logic        eret_go;
    logic [4:0]  exc_code_out;
    logic [5:0]  ip_q;
    logic        md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        output e_target, e_tnew, m_target, m_tnew,
        output md_start, md_is_div, m_pc, m_exc_code, m_eret,
        output hw_int, int_mask, ie, exl,
        input  stall, req, eret_go, exc_code_out, ip_q, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        input  e_target, e_tnew, m_target, m_tnew,
        input  md_start, md_is_div, m_pc, m_exc_code, m_eret,
        input  hw_int, int_mask, ie, exl,
        output stall, req, eret_go, exc_code_out, ip_q, md_busy
    );

endinterface

// File: rtl/pipe_ctrl_md_timer.sv
// pipe_ctrl_md_timer: HI/LO multiply/divide busy timer (IDLE/BUSY + countdown).
// In: md_start_i, md_is_div_i, kill_i. Out: md_busy_o, accept_o.
module pipe_ctrl_md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_is_div_i,
    input  logic kill_i,
    output logic md_busy_o,
    output logic accept_o
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e       state_q;
    logic [CW-1:0]   count_q;

    // A start in BUSY is ignored; a start beside a flush is squashed.
    assign accept_o  = md_start_i & ~kill_i & (state_q == MD_IDLE);
    assign md_busy_o = (state_q == MD_BUSY) | (md_start_i & ~kill_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            count_q <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (accept_o) begin
                        state_q <= MD_BUSY;
                        count_q <= md_is_div_i ? CW'(DIV_CYCLES)
                                               : CW'(MULT_CYCLES);
                    end
                end
                MD_BUSY: begin
                    // Running op is older than any flush; it keeps counting.
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer - stall, flush (req), eret redirect, IRQ/exc arbitration.
// Ports: clk, reset (async low), bus (pipe_ctrl_if.slave); PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] md_cnt
`endif
);

    logic [5:0] ip_q;
    logic       int_take;
    logic       exc_take;
    logic       req;
    logic       eret_go;
    logic       haz;
    logic       md_busy;
    logic       md_accept;
    logic       stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_q <= '0;
        end else begin
            ip_q <= bus.hw_int;
        end
    end

    assign int_take = (|(ip_q & bus.int_mask)) & bus.ie & ~bus.exl
                    & (bus.m_pc != 32'd0);
    assign exc_take = (bus.m_exc_code != 5'd0) & ~bus.exl;
    assign req      = int_take | exc_take;
    assign eret_go  = bus.m_eret & ~req;

    assign haz = src_hazard(bus.d_rs, bus.d_tuse_rs,
                            bus.e_target, bus.e_tnew,
                            bus.m_target, bus.m_tnew)
               | src_hazard(bus.d_rt, bus.d_tuse_rt,
                            bus.e_target, bus.e_tnew,
                            bus.m_target, bus.m_tnew);

    pipe_ctrl_md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md (
        .clk         (clk),
        .reset       (reset),
        .md_start_i  (bus.md_start),
        .md_is_div_i (bus.md_is_div),
        .kill_i      (req),
        .md_busy_o   (md_busy),
        .accept_o    (md_accept)
    );

    // Any flush makes the stalled instruction moot.
    assign stall = (haz | (bus.d_is_md & md_busy)) & ~req & ~eret_go;

    assign bus.stall        = stall;
    assign bus.req          = req;
    assign bus.eret_go      = eret_go;
    assign bus.exc_code_out = int_take ? EXC_INT : bus.m_exc_code;
    assign bus.ip_q         = ip_q;
    assign bus.md_busy      = md_busy;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            md_cnt    <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, stall};
            flush_cnt <= flush_cnt + {31'd0, req | eret_go};
            md_cnt    <= md_cnt + {31'd0, md_accept};
        end
    end
`endif

endmodule
